// File: rtl/fetch_queue.sv
// Instruction fetch front-end: issues sequential fetch requests, queues in-order responses
// and presents the oldest completed {pc, inst} to decode. A redirect flushes the queue.
module fetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [63:0]    fetch_pc;
    logic [63:0]    pc_mem   [DEPTH];
    logic [31:0]    inst_mem [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW-1:0]  fill;
    logic [PW-1:0]  drop_cnt;

    logic [PW-1:0]  count;
    logic [PW-1:0]  outstanding;
    logic [PW-1:0]  inflight;
    logic [PW-1:0]  drop_next;
    logic           full;
    logic           req_fire;
    logic           rsp_accept;
    logic           rsp_drop;
    logic           deliver;
    logic           unused_low_bits;

    // Handshake: a transfer happens on any cycle where valid && ready are both high; the
    // request side keeps addr stable until accepted unless a redirect withdraws it.
    assign count       = tail - head;
    assign outstanding = tail - fill;
    assign inflight    = outstanding + drop_cnt;
    assign full        = (count == PW'(DEPTH));

    assign imem_req_valid = rst && !full && (drop_cnt == '0) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_accept = imem_rsp_valid && (drop_cnt == '0) && (outstanding != '0);
    assign rsp_drop   = imem_rsp_valid && (drop_cnt != '0);

    assign if_valid = (count != '0) && filled[head[AW-1:0]];
    assign if_pc    = pc_mem[head[AW-1:0]];
    assign if_inst  = inst_mem[head[AW-1:0]];
    assign deliver  = if_valid && id_ready;

    // Everything in flight at a redirect becomes stale; a response landing that same cycle
    // is already one of them and is discarded on the spot.
    assign drop_next = (imem_rsp_valid && (inflight != '0)) ? inflight - PW'(1) : inflight;

    assign unused_low_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            drop_cnt <= '0;
            filled   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            filled   <= '0;
            fetch_pc <= {redirect_pc[63:2], 2'b00};
            drop_cnt <= drop_next;
        end else begin
            if (req_fire) begin
                pc_mem[tail[AW-1:0]] <= fetch_pc;
                filled[tail[AW-1:0]] <= 1'b0;
                tail                 <= tail + PW'(1);
                fetch_pc             <= fetch_pc + 64'd4;
            end
            if (rsp_accept) begin
                inst_mem[fill[AW-1:0]] <= imem_rsp_data;
                filled[fill[AW-1:0]]   <= 1'b1;
                fill                   <= fill + PW'(1);
            end else if (rsp_drop) begin
                drop_cnt <= drop_cnt - PW'(1);
            end
            if (deliver) begin
                head <= head + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: random memory/decode behaviour checked every cycle against a
// transaction-level model (expected pc queue, in-flight memory queue tagged by flush epoch).
module tb_fetch_queue;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          DEPTH    = 4;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    typedef struct {
        logic [63:0] addr;
        int          gen;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] del_log[$];
    int          gen, cyc, filled_cnt, errors, checks;
    logic [63:0] next_req_pc;
    int          ready_pct, id_pct, rsp_pct, lat_min, lat_max;
    int          dut_fires, first_valid_cyc;
    logic        last_if_valid, fire_seen, found;
    logic [63:0] first_fire_addr;

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic roll(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].gen != gen) n++;
        return n;
    endfunction

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver + per-cycle compare; called at posedge+1, returns at next posedge+1
    task automatic tick(input logic redir, input logic [63:0] rpc);
        logic exp_rv, exp_iv, fire, dlv, rsp;
        int   lat;
        rsp = 1'b0;
        if (mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc && roll(rsp_pct)) rsp = 1'b1;
        end
        imem_req_ready = roll(ready_pct);
        id_ready       = roll(id_pct);
        imem_rsp_valid = rsp;
        if (rsp) imem_rsp_data = mem_word(mem_q[0].addr);
        else     imem_rsp_data = $urandom();
        redirect_valid = redir;
        redirect_pc    = rpc;

        @(negedge clk);
        exp_rv = (exp_q.size() < DEPTH) && (stale_cnt() == 0) && !redir;
        exp_iv = (filled_cnt > 0);
        chk1("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk64("req_addr", imem_req_addr, next_req_pc);
        chk1("if_valid", if_valid, exp_iv);
        if (exp_iv) begin
            chk64("if_pc", if_pc, exp_q[0]);
            chk64("if_inst", {32'b0, if_inst}, {32'b0, mem_word(exp_q[0])});
        end
        last_if_valid = if_valid;
        if (imem_req_valid && imem_req_ready) begin
            dut_fires++;
            if (!fire_seen) begin
                fire_seen       = 1'b1;
                first_fire_addr = imem_req_addr;
            end
        end
        if (if_valid && id_ready && !redir) del_log.push_back(if_pc);
        if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        fire = exp_rv && imem_req_ready;
        dlv  = exp_iv && id_ready && !redir;

        @(posedge clk);
        if (rsp) begin
            if (mem_q[0].gen == gen) filled_cnt++;
            void'(mem_q.pop_front());
        end
        if (dlv) begin
            void'(exp_q.pop_front());
            filled_cnt--;
        end
        if (fire) begin
            lat = int'($urandom_range(lat_max, lat_min));
            mem_q.push_back('{next_req_pc, gen, cyc + lat});
            exp_q.push_back(next_req_pc);
            next_req_pc = next_req_pc + 64'd4;
        end
        if (redir) begin
            gen++;
            exp_q.delete();
            filled_cnt  = 0;
            next_req_pc = {rpc[63:2], 2'b00};
        end
        cyc++;
        #1;
    endtask

    // asynchronous reset, memory model reset alongside it
    task automatic do_reset();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk64("rst_if_pc", if_pc, 64'h0);
        chk64("rst_if_inst", {32'b0, if_inst}, 64'h0);
        mem_q.delete();
        exp_q.delete();
        filled_cnt  = 0;
        gen++;
        next_req_pc = RESET_PC;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        cyc = 0;
    endtask

    task automatic set_policy(input int rdy, input int rs, input int idr, input int lmin, input int lmax);
        ready_pct = rdy;
        rsp_pct   = rs;
        id_pct    = idr;
        lat_min   = lmin;
        lat_max   = lmax;
    endtask

    initial begin
        errors = 0; checks = 0; gen = 0; cyc = 0; filled_cnt = 0;
        rst = 1'b1; dut_fires = 0; first_valid_cyc = -1; fire_seen = 1'b0;
        first_fire_addr = '0; last_if_valid = 1'b0; next_req_pc = RESET_PC;
        set_policy(100, 100, 100, 1, 1);

        // streaming from reset with a 1-cycle memory
        do_reset();
        del_log.delete();
        repeat (20) tick(1'b0, 64'h0);
        chk64("first_valid_cycle", 64'(first_valid_cyc), 64'd2);
        chk64("stream_count", 64'(del_log.size()), 64'd18);
        chk64("stream_pc0", del_log[0], 64'h8000_0000);
        chk64("stream_pc1", del_log[1], 64'h8000_0004);
        chk64("stream_pc2", del_log[2], 64'h8000_0008);
        chk64("first_req_addr", first_fire_addr, 64'h8000_0000);

        // decode stalled: queue fills to DEPTH and issue stops
        do_reset();
        set_policy(100, 100, 0, 1, 1);
        dut_fires = 0;
        repeat (10) tick(1'b0, 64'h0);
        chk64("full_fires", 64'(dut_fires), 64'd4);
        chk1("full_req_valid", imem_req_valid, 1'b0);
        chk64("full_if_pc", if_pc, 64'h8000_0000);
        id_pct = 100;
        del_log.delete();
        repeat (10) tick(1'b0, 64'h0);
        for (int k = 0; k < 4; k++) chk64("drain_pc", del_log[k], RESET_PC + 64'(4 * k));

        // memory stalls and variable latency
        set_policy(50, 60, 70, 1, 3);
        repeat (300) tick(1'b0, 64'h0);

        // redirect with three responses outstanding on a 3-cycle memory
        set_policy(100, 100, 100, 3, 3);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mem_q.size() == 3 && stale_cnt() == 0) found = 1'b1;
            else tick(1'b0, 64'h0);
        end
        chk1("redir3_setup", found, 1'b1);
        fire_seen = 1'b0;
        del_log.delete();
        tick(1'b1, 64'h8000_1003);
        tick(1'b0, 64'h0);
        chk1("if_valid_after_redirect", last_if_valid, 1'b0);
        repeat (12) tick(1'b0, 64'h0);
        chk64("post_redirect_req", first_fire_addr, 64'h8000_1000);
        chk64("post_redirect_pc", del_log[0], 64'h8000_1000);

        // redirect coinciding with a response and a dequeue
        set_policy(100, 100, 100, 2, 2);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc && filled_cnt > 0 && stale_cnt() == 0)
                found = 1'b1;
            else tick(1'b0, 64'h0);
        end
        chk1("redir_same_cycle_setup", found, 1'b1);
        tick(1'b1, 64'h0000_0000_4000_2006);
        repeat (30) tick(1'b0, 64'h0);

        // random traffic with occasional redirects, including one near address wrap
        set_policy(80, 75, 75, 1, 4);
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2)       tick(1'b1, {$urandom(), $urandom()});
            else if (r == 2) tick(1'b1, 64'hFFFF_FFFF_FFFF_FFF5);
            else             tick(1'b0, 64'h0);
        end

        // reset while full with two requests in flight
        set_policy(100, 100, 0, 6, 6);
        tick(1'b1, 64'h8000_3000);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (exp_q.size() == DEPTH && mem_q.size() == 2 && stale_cnt() == 0) found = 1'b1;
            else tick(1'b0, 64'h0);
        end
        chk1("reset_full_setup", found, 1'b1);
        fire_seen = 1'b0;
        do_reset();
        set_policy(100, 100, 100, 1, 1);
        repeat (10) tick(1'b0, 64'h0);
        chk64("post_reset_req", first_fire_addr, RESET_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
